// File: rtl/ram_sync_dp_be.sv
// Simple-dual-port synchronous RAM with byte write enables, a registered read port
// with a valid strobe, selectable read-during-write data and an optional zero-fill sweep.
module ram_sync_dp_be #(
    parameter int AWIDTH    = 3,
    parameter int DWIDTH    = 32,
    parameter int RDW_MODE  = 0,
    parameter int INIT_ZERO = 1,
    localparam int DEPTH    = 1 << AWIDTH,
    localparam int NBYTES   = DWIDTH / 8
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_busy,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] din,
    input  logic [NBYTES-1:0] wbe,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] dout,
    output logic              dout_valid
);

    if (DWIDTH % 8 != 0) begin : g_bad_width
        $fatal(1, "ram_sync_dp_be: DWIDTH must be a multiple of 8");
    end

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

    logic [DWIDTH-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;

    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [NBYTES-1:0] mem_be;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] rd_old;
    logic [DWIDTH-1:0] rd_merged;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = waddr;
        mem_be       = wbe;
        mem_wdata    = din;

        rd_old    = mem[raddr];
        rd_merged = rd_old;
        for (int i = 0; i < NBYTES; i++) begin
            if (wbe[i]) begin
                rd_merged[8*i +: 8] = din[8*i +: 8];
            end
        end

        case (state_q)
            S_INIT: begin
                // Sweep owns the write port; user requests are dropped.
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_be    = '1;
                mem_wdata = '0;
                cnt_d     = cnt_q + AWIDTH'(1);
                dout_d    = '0;
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                mem_we = we;
                if (re) begin
                    dout_valid_d = 1'b1;
                    if (RDW_MODE == 1 && we && (waddr == raddr)) begin
                        dout_d = rd_merged;
                    end else begin
                        dout_d = rd_old;
                    end
                end
            end
            default: begin
                state_d = S_READY;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= (INIT_ZERO != 0) ? S_INIT : S_READY;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Storage is not reset; the reset gate keeps a write from landing while held in reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (mem_we && !reset && mem_be[i]) begin
                mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    assign init_busy  = (state_q == S_INIT);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_ram_sync_dp_be.sv
// Bench for ram_sync_dp_be: three instances (old-data, new-data, no-sweep) share one
// directed stimulus; a word-level model is compared every cycle plus literal pins.
module tb_ram_sync_dp_be;

    localparam bit [2:0] IZ  = 3'b011;
    localparam bit [2:0] RDW = 3'b010;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  waddr = '0;
    logic [31:0] din = '0;
    logic [3:0]  wbe = '0;
    logic        re = 1'b0;
    logic [2:0]  raddr = '0;

    logic [31:0] dout_w [3];
    logic        dv_w   [3];
    logic        busy_w [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    ram_sync_dp_be #(.AWIDTH(3), .DWIDTH(32), .RDW_MODE(0), .INIT_ZERO(1)) dut0 (
        .clock(clock), .reset(reset), .init_busy(busy_w[0]), .we(we), .waddr(waddr),
        .din(din), .wbe(wbe), .re(re), .raddr(raddr), .dout(dout_w[0]), .dout_valid(dv_w[0]));
    ram_sync_dp_be #(.AWIDTH(3), .DWIDTH(32), .RDW_MODE(1), .INIT_ZERO(1)) dut1 (
        .clock(clock), .reset(reset), .init_busy(busy_w[1]), .we(we), .waddr(waddr),
        .din(din), .wbe(wbe), .re(re), .raddr(raddr), .dout(dout_w[1]), .dout_valid(dv_w[1]));
    ram_sync_dp_be #(.AWIDTH(3), .DWIDTH(32), .RDW_MODE(0), .INIT_ZERO(0)) dut2 (
        .clock(clock), .reset(reset), .init_busy(busy_w[2]), .we(we), .waddr(waddr),
        .din(din), .wbe(wbe), .re(re), .raddr(raddr), .dout(dout_w[2]), .dout_valid(dv_w[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: remaining sweep cycles, memory image with known flags, expected outputs.
    int          busy_left [3];
    logic [31:0] mmem   [3][8];
    bit          mknown [3][8];
    logic [31:0] e_dout [3];
    bit          e_dv   [3];
    bit          e_known[3];

    initial begin
        for (int m = 0; m < 3; m++) begin
            busy_left[m] = 0;
            e_dout[m] = '0;
            e_dv[m] = 1'b0;
            e_known[m] = 1'b0;
            for (int a = 0; a < 8; a++) begin
                mmem[m][a] = '0;
                mknown[m][a] = 1'b0;
            end
        end
    end

    always @(posedge clock or posedge reset) begin
        for (int m = 0; m < 3; m++) begin
            if (reset) begin
                busy_left[m] = IZ[m] ? 8 : 0;
                e_dout[m] = '0;
                e_dv[m] = 1'b0;
                e_known[m] = 1'b1;
            end else if (busy_left[m] > 0) begin
                busy_left[m]--;
                e_dv[m] = 1'b0;
                if (busy_left[m] == 0) begin
                    for (int a = 0; a < 8; a++) begin
                        mmem[m][a] = '0;
                        mknown[m][a] = 1'b1;
                    end
                end
            end else begin
                logic [31:0] nw;
                nw = mmem[m][waddr];
                for (int b = 0; b < 4; b++) begin
                    if (wbe[b]) nw[8*b +: 8] = din[8*b +: 8];
                end
                e_dv[m] = re;
                if (re) begin
                    if (we && waddr == raddr && RDW[m]) begin
                        e_dout[m] = nw;
                        e_known[m] = mknown[m][raddr] || (wbe == 4'hF);
                    end else begin
                        e_dout[m] = mmem[m][raddr];
                        e_known[m] = mknown[m][raddr];
                    end
                end
                if (we) begin
                    mmem[m][waddr] = nw;
                    mknown[m][waddr] = mknown[m][waddr] || (wbe == 4'hF);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            for (int m = 0; m < 3; m++) begin
                chk($sformatf("model_busy%0d", m), {31'd0, busy_w[m]}, {31'd0, busy_left[m] > 0});
                chk($sformatf("model_valid%0d", m), {31'd0, dv_w[m]}, {31'd0, e_dv[m]});
                if (e_known[m]) chk($sformatf("model_dout%0d", m), dout_w[m], e_dout[m]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int n;

    initial begin
        #1 reset = 1'b1;
        #1;
        for (int m = 0; m < 3; m++) begin
            chk("reset_dout", dout_w[m], 32'h0);
            chk("reset_valid", {31'd0, dv_w[m]}, 32'h0);
        end
        chk("reset_busy0", {31'd0, busy_w[0]}, 32'h1);
        chk("reset_busy2", {31'd0, busy_w[2]}, 32'h0);
        @(negedge clock);
        @(negedge clock);

        // Zero-fill with a write and read held across the sweep.
        we = 1'b1; waddr = 3'd3; din = 32'hDEADBEEF; wbe = 4'hF;
        re = 1'b1; raddr = 3'd3;
        reset = 1'b0;
        chk_en = 1'b1;
        n = 0;
        while (busy_w[0] && n < 30) begin
            n++;
            if (n == 3) begin
                chk("noinit_first_rw", dout_w[2], 32'hDEADBEEF);
                chk("noinit_valid", {31'd0, dv_w[2]}, 32'h1);
                chk("init_read_ignored", {31'd0, dv_w[0]}, 32'h0);
                chk("init_dout_zero", dout_w[0], 32'h0);
            end
            @(negedge clock);
        end
        chk("zero_fill_busy_cycles", n, 32'd8);

        we = 1'b0;
        for (int a = 0; a < 8; a++) begin
            raddr = 3'(a);
            @(negedge clock);
            chk("zero_fill_read", dout_w[0], 32'h0);
            chk("zero_fill_valid", {31'd0, dv_w[0]}, 32'h1);
        end
        re = 1'b0;

        // Byte enables
        we = 1'b1; waddr = 3'd5; din = 32'hAABBCCDD; wbe = 4'hF;
        @(negedge clock);
        din = 32'h11223344; wbe = 4'b0101;
        @(negedge clock);
        we = 1'b0; re = 1'b1; raddr = 3'd5;
        @(negedge clock);
        for (int m = 0; m < 3; m++) chk("byte_enable", dout_w[m], 32'hAA22CC44);
        re = 1'b0;
        @(negedge clock);
        chk("valid_single_pulse", {31'd0, dv_w[0]}, 32'h0);

        // Read-during-write
        we = 1'b1; waddr = 3'd2; din = 32'h00000001; wbe = 4'hF;
        @(negedge clock);
        din = 32'hFFFFFFFF; wbe = 4'b0011; re = 1'b1; raddr = 3'd2;
        @(negedge clock);
        chk("rdw_old", dout_w[0], 32'h00000001);
        chk("rdw_new", dout_w[1], 32'h0000FFFF);
        we = 1'b0;
        @(negedge clock);
        chk("rdw_after0", dout_w[0], 32'h0000FFFF);
        chk("rdw_after1", dout_w[1], 32'h0000FFFF);
        re = 1'b0;

        // Streaming
        we = 1'b1; wbe = 4'hF;
        for (int a = 0; a < 8; a++) begin
            waddr = 3'(a); din = 32'h100 + 32'(a);
            @(negedge clock);
        end
        we = 1'b0; re = 1'b1;
        for (int a = 0; a < 8; a++) begin
            raddr = 3'(a);
            @(negedge clock);
            chk("stream_dout", dout_w[0], 32'h100 + 32'(a));
            chk("stream_valid", {31'd0, dv_w[0]}, 32'h1);
        end
        re = 1'b0;
        @(negedge clock);
        chk("stream_hold", dout_w[0], 32'h107);
        chk("stream_valid_drop", {31'd0, dv_w[0]}, 32'h0);

        // Reset with a read accepted on the same cycle
        re = 1'b1; raddr = 3'd7;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        for (int m = 0; m < 3; m++) begin
            chk("async_reset_dout", dout_w[m], 32'h0);
            chk("async_reset_valid", {31'd0, dv_w[m]}, 32'h0);
        end
        @(negedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #2 chk("mid_sweep_busy", {31'd0, busy_w[0]}, 32'h1);
        reset = 1'b1;
        @(negedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        while (busy_w[0] && n < 30) begin
            n++;
            @(negedge clock);
        end
        chk("restart_busy_cycles", n, 32'd8);
        @(negedge clock);
        chk("swept_after_reset", dout_w[0], 32'h0);
        chk("swept_valid", {31'd0, dv_w[0]}, 32'h1);
        chk("noinit_preserved", dout_w[2], 32'h107);
        re = 1'b0;
        @(negedge clock);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_sync_dp_be.md
Name: ram_sync_dp_be

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port, one read port, one clock.
- Generational upgrade of the team's single-port sync-read RAM: per-byte write enables, fully registered read data with a valid strobe, and selectable read-during-write behaviour.
- Optional hardware zero-fill after reset, so no memory init file is needed.
- Used as the general storage primitive in datapath buffers and coefficient stores.

Parameters:
- AWIDTH, 3, address width; DEPTH = 1 << AWIDTH (derived, not overridable).
- DWIDTH, 32, data width; must be a multiple of 8 (elaboration-time check, fatal otherwise).
- NBYTES, DWIDTH/8, byte-lane count (derived, not overridable).
- RDW_MODE, 0, same-address read-during-write behaviour: 0 = old data, 1 = new (merged) data.
- INIT_ZERO, 1, 1 = zero-fill sweep after reset, 0 = no sweep (contents undefined after reset).

Ports:
- clock, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-high reset.
- init_busy, out, 1, high while the zero-fill sweep runs.
- we, in, 1, write request.
- waddr, in, AWIDTH, write address.
- din, in, DWIDTH, write data.
- wbe, in, NBYTES, byte write enables; bit i covers din[8i+7:8i].
- re, in, 1, read request.
- raddr, in, AWIDTH, read address.
- dout, out, DWIDTH, registered read data.
- dout_valid, out, 1, high for exactly one cycle per accepted read.

Behaviour:
- Reset (asynchronous assert; deassert sampled on clock):
  - dout = 0, dout_valid = 0, sweep counter = 0.
  - State = INIT if INIT_ZERO = 1, else READY.
  - init_busy = 1 in INIT, 0 in READY.
- Two-state FSM, INIT and READY:
  - INIT: each cycle writes 0 to mem[cnt] and increments cnt.
  - On the cycle that writes address DEPTH-1, cnt wraps to 0 and the next state is READY.
  - init_busy is high for exactly DEPTH cycles after reset release, then falls.
  - READY is terminal until reset.
- In INIT: we and re are ignored (no write, no read); dout holds 0 and dout_valid stays 0.
- Write in READY, at the edge where we = 1:
  - For each i with wbe[i] = 1, lane i of mem[waddr] takes din lane i.
  - Lanes with wbe[i] = 0 are unchanged.
  - we = 1 with wbe = 0 is a legal no-op.
- Read in READY:
  - re = 1 at edge N: dout = mem[raddr] and dout_valid = 1 after edge N (latency 1, fully registered).
  - re = 0: dout holds its previous value and dout_valid = 0.
  - Back-to-back reads every cycle are supported; throughput is 1 word per clock.
- Read-during-write, same edge, re & we with raddr == waddr:
  - RDW_MODE = 0: dout = word before the write.
  - RDW_MODE = 1: dout = merged word (din lanes where wbe = 1, old lanes elsewhere).
  - The memory update is identical in both modes.
  - Different addresses never interact.
- Reset mid-sweep: the sweep restarts from address 0 and init_busy re-asserts for a full DEPTH cycles.
- Reset mid-operation: a read accepted on the reset edge is discarded (dout = 0, dout_valid = 0). Memory contents are not preserved when INIT_ZERO = 1.
- INIT_ZERO = 0:
  - No sweep; init_busy is constant 0.
  - Reads of never-written words return X in simulation.
  - Reset affects only dout, dout_valid and the FSM.
- Address arithmetic: sweep counter is AWIDTH bits and wraps naturally. Out-of-range addresses are impossible by construction.

Test Plan:
- Zero-fill (AWIDTH=3, INIT_ZERO=1): release reset, hold we=1 during INIT -> init_busy high for exactly 8 cycles; all 8 addresses then read 0x00000000 with dout_valid pulses; no writes land.
- Byte enables: write 0xAABBCCDD to addr 5 with wbe=4'hF, then 0x11223344 with wbe=4'b0101 -> read of addr 5 returns 0xAA22CC44, one cycle after re.
- Read-during-write: addr 2 = 0x00000001; same edge write 0xFFFFFFFF (wbe=4'b0011) and read addr 2 -> dout = 0x00000001 with RDW_MODE=0, 0x0000FFFF with RDW_MODE=1; next read returns 0x0000FFFF in both modes.
- Streaming: re=1 for 8 consecutive cycles, raddr 0..7 after writing data = 0x100+addr -> dout_valid high 8 cycles, dout sequence 0x100..0x107, no bubbles; dout holds 0x107 after re drops.
- Reset mid-sweep: assert reset at INIT cycle 4 for 1 cycle -> init_busy stays high and the sweep takes a full 8 more cycles; dout/dout_valid = 0 immediately on assertion (asynchronous).
- INIT_ZERO=0: release reset -> init_busy never asserts; write/read work on the first cycle after reset release.
